// File: rtl/inc_burst_gen.sv
// Streaming incrementer: a start handshake (a, n) yields beats a+1 .. a+n on a valid/ready stream.
// Optional build macro INC_BURST_SATURATE_EN ends the burst at the all-ones value instead of wrapping.
module inc_burst_gen #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] n,
  output logic [DATAWIDTH-1:0] d,
  output logic                 d_valid,
  input  logic                 d_ready,
  output logic                 d_last,
  output logic                 done,
  output logic                 wrap
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [DATAWIDTH-1:0] ZERO_C = {DATAWIDTH{1'b0}};
  localparam logic [DATAWIDTH-1:0] ONE_C  = {{(DATAWIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATAWIDTH-1:0] TWO_C  = {{(DATAWIDTH-2){1'b0}}, 2'b10};

  function automatic logic is_ones(input logic [DATAWIDTH-1:0] v);
    return &v;
  endfunction

  state_e                 state_q, state_d;
  logic [DATAWIDTH-1:0]   d_q, d_d;
  logic [DATAWIDTH-1:0]   rem_q, rem_d;
  logic                   d_valid_q, d_valid_d;
  logic                   d_last_q, d_last_d;
  logic                   done_q, done_d;
  logic                   wrap_q, wrap_d;
  logic [DATAWIDTH-1:0]   first_s;
  logic [DATAWIDTH-1:0]   next_s;
  logic                   end_beat_s;

  // Next-state and registered-output decode for the IDLE/RUN controller
  always_comb begin
    state_d    = state_q;
    d_d        = d_q;
    rem_d      = rem_q;
    d_valid_d  = d_valid_q;
    d_last_d   = d_last_q;
    done_d     = 1'b0;
    wrap_d     = wrap_q;
    next_s     = d_q + ONE_C;
`ifdef INC_BURST_SATURATE_EN
    first_s    = is_ones(a) ? a : (a + ONE_C);
    end_beat_s = (rem_q == ONE_C) || is_ones(d_q);
`else
    first_s    = a + ONE_C;
    end_beat_s = (rem_q == ONE_C);
`endif

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          wrap_d = 1'b0;
          if (n == ZERO_C) begin
            done_d = 1'b1;
          end else begin
            d_d       = first_s;
            wrap_d    = is_ones(a);
            rem_d     = n;
            d_valid_d = 1'b1;
`ifdef INC_BURST_SATURATE_EN
            d_last_d  = (n == ONE_C) || is_ones(first_s);
`else
            d_last_d  = (n == ONE_C);
`endif
            state_d   = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (d_ready) begin
          if (end_beat_s) begin
            d_valid_d = 1'b0;
            d_last_d  = 1'b0;
            done_d    = 1'b1;
            rem_d     = ZERO_C;
            state_d   = IDLE;
`ifdef INC_BURST_SATURATE_EN
            // Reaching all-ones always marks the burst as saturated
            wrap_d    = wrap_q | is_ones(d_q);
`else
            wrap_d    = wrap_q;
`endif
          end else begin
            d_d    = next_s;
            rem_d  = rem_q - ONE_C;
            wrap_d = wrap_q | is_ones(d_q);
`ifdef INC_BURST_SATURATE_EN
            d_last_d = (rem_q == TWO_C) || is_ones(next_s);
`else
            d_last_d = (rem_q == TWO_C);
`endif
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = IDLE;
        d_valid_d = 1'b0;
        d_last_d  = 1'b0;
        rem_d     = ZERO_C;
      end
    endcase
  end

  // State and output registers, cleared asynchronously while Rst is low
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      d_q       <= ZERO_C;
      rem_q     <= ZERO_C;
      d_valid_q <= 1'b0;
      d_last_q  <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      rem_q     <= rem_d;
      d_valid_q <= d_valid_d;
      d_last_q  <= d_last_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign d           = d_q;
  assign d_valid     = d_valid_q;
  assign d_last      = d_last_q;
  assign done        = done_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_inc_burst_gen.sv
// Randomised self-checking bench for inc_burst_gen; expected beats come from plain arithmetic on (a, n).
module tb_inc_burst_gen;

  logic       Clk;
  logic       Rst;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] a;
  logic [7:0] n;
  logic [7:0] d;
  logic       d_valid;
  logic       d_ready;
  logic       d_last;
  logic       done;
  logic       wrap;

  int total;
  int bad;

  inc_burst_gen #(.DATAWIDTH(8)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a          (a),
    .n          (n),
    .d          (d),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .d_last     (d_last),
    .done       (done),
    .wrap       (wrap)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: number of beats actually emitted for a start (a, n)
  function automatic int eff_beats(input int av, input int nv);
`ifdef INC_BURST_SATURATE_EN
    if (nv == 0) return 0;
    if (av == 255) return 1;
    if (av + nv > 255) return 255 - av;
    return nv;
`else
    return nv;
`endif
  endfunction

  function automatic int exp_d(input int av, input int i);
`ifdef INC_BURST_SATURATE_EN
    if (av == 255) return 255;
`endif
    return (av + i) % 256;
  endfunction

  function automatic int exp_wrap_beat(input int av, input int i);
`ifdef INC_BURST_SATURATE_EN
    return (av == 255) ? 1 : 0;
`else
    return (av + i >= 256) ? 1 : 0;
`endif
  endfunction

  function automatic int exp_wrap_end(input int av, input int nb);
`ifdef INC_BURST_SATURATE_EN
    return (av == 255 || av + nb == 255) ? 1 : 0;
`else
    return (av + nb >= 256) ? 1 : 0;
`endif
  endfunction

  task automatic run_burst(input int av, input int nv, input int stall_first,
                           input bit rnd, input bit noise);
    int i;
    int cyc;
    int nb;
    nb = eff_beats(av, nv);
    check("start_ready_pre", start_ready, 1);
    start_valid = 1'b1;
    a           = 8'(av);
    n           = 8'(nv);
    d_ready     = 1'b0;
    @(posedge Clk); #1;
    start_valid = 1'b0;
    a           = 8'($urandom);
    n           = 8'($urandom);
    if (nb == 0) begin
      check("zero_done", done, 1);
      check("zero_valid", d_valid, 0);
      check("zero_ready", start_ready, 1);
      check("zero_wrap", wrap, 0);
    end else begin
      i   = 1;
      cyc = 0;
      while (i <= nb && cyc < 2000) begin
        check("beat_valid", d_valid, 1);
        check("beat_d", d, exp_d(av, i));
        check("beat_last", d_last, (i == nb) ? 1 : 0);
        check("beat_wrap", wrap, exp_wrap_beat(av, i));
        check("beat_done", done, 0);
        check("beat_start_ready", start_ready, 0);
        if (cyc < stall_first) d_ready = 1'b0;
        else if (rnd) d_ready = ($urandom_range(0, 3) != 0);
        else d_ready = 1'b1;
        start_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        a           = 8'($urandom);
        n           = 8'($urandom);
        @(posedge Clk); #1;
        if (d_ready) i++;
        cyc++;
      end
      start_valid = 1'b0;
      d_ready     = 1'b0;
      if (cyc >= 2000) check("beat_timeout", 1, 0);
      check("end_done", done, 1);
      check("end_valid", d_valid, 0);
      check("end_last", d_last, 0);
      check("end_start_ready", start_ready, 1);
      check("end_d_hold", d, exp_d(av, nb));
      check("end_wrap", wrap, exp_wrap_end(av, nb));
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    Rst         = 1'b0;
    start_valid = 1'b0;
    a           = 8'd0;
    n           = 8'd0;
    d_ready     = 1'b0;
    #1;
    check("rst_d", d, 0);
    check("rst_valid", d_valid, 0);
    check("rst_last", d_last, 0);
    check("rst_done", done, 0);
    check("rst_wrap", wrap, 0);
    check("rst_start_ready", start_ready, 1);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk); #1;

    run_burst(10, 3, 0, 1'b0, 1'b0);
    run_burst(20, 2, 3, 1'b0, 1'b0);
    run_burst(254, 3, 0, 1'b0, 1'b0);
    run_burst(5, 0, 0, 1'b0, 1'b0);
    @(posedge Clk); #1;
    check("zero_done_pulse", done, 0);
    check("zero_ready_idle", start_ready, 1);
    run_burst(30, 4, 0, 1'b0, 1'b1);
    run_burst(255, 2, 0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a burst
    start_valid = 1'b1;
    a           = 8'd0;
    n           = 8'd5;
    @(posedge Clk); #1;
    start_valid = 1'b0;
    d_ready     = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("mid_d", d, 3);
    #2;
    Rst = 1'b0;
    #1;
    check("arst_d", d, 0);
    check("arst_valid", d_valid, 0);
    check("arst_last", d_last, 0);
    check("arst_done", done, 0);
    check("arst_start_ready", start_ready, 1);
    d_ready = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk); #1;
    check("post_rst_valid", d_valid, 0);
    run_burst(100, 1, 0, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      int av;
      int nv;
      av = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) av = $urandom_range(240, 255);
      nv = $urandom_range(0, 12);
      if ($urandom_range(0, 9) == 0) nv = $urandom_range(0, 255);
      run_burst(av, nv, $urandom_range(0, 2), 1'b1, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge Clk); #1;
        check("idle_done", done, 0);
        check("idle_valid", d_valid, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
